// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard control with a load-latency scoreboard.
// Resolves redirect, load-use, external stall and illegal-instruction hazards
// for a 4-register pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Parameters:
//   LOAD_LAT      (1..3)  cycles after a load leaves ID before it forwards
//   FLUSH_DEPTH   (1..3)  registers flushed on redirect, from IF/ID upward
//   STALL_TIMEOUT         ext_stall watchdog limit in cycles
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   id_*                  instruction currently in ID
//   jump_branch_taken     redirect from EX
//   invalid_inst          illegal instruction in ID
//   ext_stall             multi-cycle unit busy
//   stage_en/stage_flush  per pipeline register enable / flush
//   pc_en, load_stall     PC enable, load-use stall indication
//   stall_timeout         sticky watchdog flag
//   *_cnt                 performance counters
// Macro HAZARD_PERF_CNT_EN: enables the saturating performance counters;
// without it the counter ports are tied to zero.
module hazard_scoreboard #(
    parameter int LOAD_LAT      = 1,
    parameter int FLUSH_DEPTH   = 3,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_load,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        jump_branch_taken,
    input  logic        invalid_inst,
    input  logic        ext_stall,
    output logic [3:0]  stage_en,
    output logic [3:0]  stage_flush,
    output logic        pc_en,
    output logic        load_stall,
    output logic        stall_timeout,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] ext_stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        LSTALL,
        XSTALL
    } state_t;

    localparam logic [3:0]  FLUSH_MASK = 4'((1 << FLUSH_DEPTH) - 1);
    localparam logic [31:0] TIMEOUT    = 32'(STALL_TIMEOUT);

    logic [LOAD_LAT-1:0] sb_valid;
    logic [4:0]          sb_rd [LOAD_LAT];

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wd_cnt;
    logic [15:0] wd_nxt;

    logic hit;
    logic load_hazard;
    logic redirect;
    logic lstall_sel;
    logic xstall_sel;
    logic issue;

    // Any in-flight load whose result is not yet forwardable.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_valid[i] &&
                ((id_rs1_used && (sb_rd[i] == id_rs1)) ||
                 (id_rs2_used && (sb_rd[i] == id_rs2)))) begin
                hit = 1'b1;
            end
        end
    end

    assign load_hazard = id_valid && hit;
    assign redirect    = jump_branch_taken;
    assign lstall_sel  = !redirect && load_hazard;
    assign xstall_sel  = !redirect && !load_hazard && ext_stall;
    // ID advances into EX only when nothing blocks or kills it.
    assign issue       = !redirect && !load_hazard && !ext_stall &&
                         id_valid && id_load && (id_rd != 5'd0);

    // Scoreboard: entry0 is the load that just left ID.
    // It freezes only while the external stall is the chosen cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_valid <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                sb_rd[i] <= '0;
            end
        end else if (!xstall_sel) begin
            sb_valid[0] <= issue;
            sb_rd[0]    <= id_rd;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

    always_comb begin
        stage_en    = 4'b1111;
        stage_flush = 4'b0000;
        pc_en       = 1'b1;
        load_stall  = 1'b0;
        if (!rst_n) begin
            stage_flush = 4'b1111;
            pc_en       = 1'b0;
        end else if (redirect) begin
            stage_flush = FLUSH_MASK;
        end else if (load_hazard) begin
            stage_en[0]    = 1'b0;
            pc_en          = 1'b0;
            stage_flush[1] = 1'b1;
            load_stall     = 1'b1;
        end else if (ext_stall) begin
            stage_en[1:0] = 2'b00;
            pc_en         = 1'b0;
        end else if (invalid_inst) begin
            stage_flush[1] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = RUN;
        if (lstall_sel) begin
            state_nxt = LSTALL;
        end else if (xstall_sel) begin
            state_nxt = XSTALL;
        end
    end

    // Watchdog saturates rather than wrapping.
    always_comb begin
        wd_nxt = 16'd0;
        if ((state == XSTALL) && ext_stall) begin
            wd_nxt = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            wd_cnt        <= 16'd0;
            stall_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_nxt;
            if (32'(wd_nxt) >= TIMEOUT) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lcnt;
    logic [31:0] xcnt;
    logic [31:0] fcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcnt <= '0;
            xcnt <= '0;
            fcnt <= '0;
        end else begin
            if (lstall_sel && (lcnt != '1)) begin
                lcnt <= lcnt + 32'd1;
            end
            if (xstall_sel && (xcnt != '1)) begin
                xcnt <= xcnt + 32'd1;
            end
            if (redirect && (fcnt != '1)) begin
                fcnt <= fcnt + 32'd1;
            end
        end
    end

    assign load_stall_cnt = lcnt;
    assign ext_stall_cnt  = xcnt;
    assign flush_cnt      = fcnt;
`else
    assign load_stall_cnt = 32'd0;
    assign ext_stall_cnt  = 32'd0;
    assign flush_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic
// against a list-of-pending-loads reference model, two configurations.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       rst_n, id_valid, id_load, rs1_used, rs2_used;
    logic       jbt, inv, xst;
    logic [4:0] rs1, rs2, rd;

    logic [3:0]  en_a, fl_a, en_b, fl_b;
    logic        pc_a, ls_a, to_a, pc_b, ls_b, to_b;
    logic [31:0] lc_a, xc_a, fc_a, lc_b, xc_b, fc_b;
    logic [9:0]  bun_a, bun_b;

    assign bun_a = {en_a, fl_a, pc_a, ls_a};
    assign bun_b = {en_b, fl_b, pc_b, ls_b};

    int checks = 0;
    int errors = 0;
    int pool [5] = '{0, 1, 2, 5, 7};

    hazard_scoreboard #(
        .LOAD_LAT(1), .FLUSH_DEPTH(3), .STALL_TIMEOUT(1024)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_load(id_load), .id_rs1(rs1), .id_rs2(rs2), .id_rd(rd),
        .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
        .jump_branch_taken(jbt), .invalid_inst(inv),
        .ext_stall(xst), .stage_en(en_a), .stage_flush(fl_a),
        .pc_en(pc_a), .load_stall(ls_a), .stall_timeout(to_a),
        .load_stall_cnt(lc_a), .ext_stall_cnt(xc_a),
        .flush_cnt(fc_a)
    );

    hazard_scoreboard #(
        .LOAD_LAT(3), .FLUSH_DEPTH(2), .STALL_TIMEOUT(1024)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_load(id_load), .id_rs1(rs1), .id_rs2(rs2), .id_rd(rd),
        .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
        .jump_branch_taken(jbt), .invalid_inst(inv),
        .ext_stall(xst), .stage_en(en_b), .stage_flush(fl_b),
        .pc_en(pc_b), .load_stall(ls_b), .stall_timeout(to_b),
        .load_stall_cnt(lc_b), .ext_stall_cnt(xc_b),
        .flush_cnt(fc_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_load = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0;
        jbt = 1'b0; inv = 1'b0; xst = 1'b0;
    endtask

    task automatic ld(input logic [4:0] d);
        clr();
        id_valid = 1'b1; id_load = 1'b1; rd = d;
    endtask

    task automatic rdr(input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub);
        clr();
        id_valid = 1'b1; rd = 5'd6;
        rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr();
        #3;
        checks++;
        if (bun_a !== 10'b1111_1111_0_0 || bun_b !== 10'b1111_1111_0_0) begin
            errors++;
            $display("FAIL rst_forced a=%b b=%b want 1111111100", bun_a, bun_b);
        end
        step();
        rst_n = 1'b1;
        #3;
        checks++;
        if (bun_a !== 10'b1111_0000_1_0 || bun_b !== 10'b1111_0000_1_0) begin
            errors++;
            $display("FAIL rst_default a=%b b=%b want 1111000010", bun_a, bun_b);
        end
        checks++;
        if ({to_a, to_b} !== 2'b00 ||
            {lc_a, xc_a, fc_a, lc_b, xc_b, fc_b} !== 192'd0) begin
            errors++;
            $display("FAIL rst_state to=%b%b cnt_a=%0d/%0d/%0d want 0",
                     to_a, to_b, lc_a, xc_a, fc_a);
        end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        ld(5'd5);
        #3;
        checks++;
        if (ls_a !== 1'b0 || ls_b !== 1'b0) begin
            errors++;
            $display("FAIL lu_issue ls=%b%b want 00", ls_a, ls_b);
        end
        step();
        rdr(5'd5, 1'b1, 5'd1, 1'b1);
        #3;
        checks++;
        if (bun_a !== 10'b1110_0010_0_1) begin
            errors++;
            $display("FAIL lu_stall a=%b want 1110001001", bun_a);
        end
        step();
        #3;
        checks++;
        if (bun_a !== 10'b1111_0000_1_0) begin
            errors++;
            $display("FAIL lu_release a=%b want 1111000010", bun_a);
        end
        step();
    endtask

    task automatic test_lat3();
        logic [5:0] pat;
        do_reset();
        ld(5'd7);
        step();
        rdr(5'd7, 1'b1, 5'd0, 1'b0);
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            #3;
            pat[c] = ls_b;
            step();
        end
        checks++;
        if (pat !== 6'b000111) begin
            errors++;
            $display("FAIL lat3_pattern got %b want 000111", pat);
        end
        checks++;
        if (lc_b !== (PERF ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL lat3_cnt got %0d want %0d", lc_b, PERF ? 3 : 0);
        end
        ld(5'd7);
        step();
        rdr(5'd8, 1'b1, 5'd8, 1'b1);
        #3;
        checks++;
        if (ls_a !== 1'b0 || ls_b !== 1'b0) begin
            errors++;
            $display("FAIL lat3_other ls=%b%b want 00", ls_a, ls_b);
        end
        step();
    endtask

    task automatic test_x0_unused();
        do_reset();
        ld(5'd0);
        step();
        rdr(5'd0, 1'b1, 5'd0, 1'b1);
        #3;
        checks++;
        if (ls_a !== 1'b0 || ls_b !== 1'b0) begin
            errors++;
            $display("FAIL x0_load ls=%b%b want 00", ls_a, ls_b);
        end
        step();
        ld(5'd5);
        step();
        rdr(5'd3, 1'b1, 5'd5, 1'b0);
        #3;
        checks++;
        if (ls_a !== 1'b0 || ls_b !== 1'b0) begin
            errors++;
            $display("FAIL rs2_unused ls=%b%b want 00", ls_a, ls_b);
        end
        step();
    endtask

    task automatic test_redirect();
        do_reset();
        ld(5'd7);
        step();
        rdr(5'd7, 1'b1, 5'd0, 1'b0);
        jbt = 1'b1;
        #3;
        checks++;
        if (bun_b !== 10'b1111_0011_1_0) begin
            errors++;
            $display("FAIL redir_fd2 b=%b want 1111001110", bun_b);
        end
        checks++;
        if (bun_a !== 10'b1111_0111_1_0) begin
            errors++;
            $display("FAIL redir_fd3 a=%b want 1111011110", bun_a);
        end
        step();
        jbt = 1'b0;
        #3;
        checks++;
        if (ls_a !== 1'b0 || ls_b !== 1'b1) begin
            errors++;
            $display("FAIL redir_after ls=%b%b want 01", ls_a, ls_b);
        end
        checks++;
        if (fc_a !== (PERF ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL redir_cnt got %0d want %0d", fc_a, PERF ? 1 : 0);
        end
        step();
    endtask

    task automatic test_priority();
        do_reset();
        clr();
        id_valid = 1'b1; xst = 1'b1; inv = 1'b1;
        #3;
        checks++;
        if (bun_a !== 10'b1100_0000_0_0 || bun_b !== 10'b1100_0000_0_0) begin
            errors++;
            $display("FAIL xst_over_inv a=%b b=%b want 1100000000", bun_a, bun_b);
        end
        step();
        xst = 1'b0;
        #3;
        checks++;
        if (bun_a !== 10'b1111_0010_1_0 || bun_b !== 10'b1111_0010_1_0) begin
            errors++;
            $display("FAIL inv_flush a=%b b=%b want 1111001010", bun_a, bun_b);
        end
        step();
        ld(5'd5);
        step();
        rdr(5'd5, 1'b1, 5'd0, 1'b0);
        xst = 1'b1;
        #3;
        checks++;
        if (bun_a !== 10'b1110_0010_0_1 || bun_b !== 10'b1110_0010_0_1) begin
            errors++;
            $display("FAIL lh_over_xst a=%b b=%b want 1110001001", bun_a, bun_b);
        end
        step();
    endtask

    task automatic test_hold();
        logic [3:0] pat;
        do_reset();
        ld(5'd9);
        step();
        clr();
        xst = 1'b1;
        for (int c = 0; c < 4; c++) step();
        rdr(5'd9, 1'b1, 5'd0, 1'b0);
        pat = '0;
        for (int c = 0; c < 4; c++) begin
            #3;
            if (c == 0) begin
                checks++;
                if (bun_a !== 10'b1110_0010_0_1) begin
                    errors++;
                    $display("FAIL hold_lat1 a=%b want 1110001001", bun_a);
                end
            end
            pat[c] = ls_b;
            step();
        end
        checks++;
        if (pat !== 4'b0111) begin
            errors++;
            $display("FAIL hold_lat3 got %b want 0111", pat);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        clr();
        xst = 1'b1;
        for (int c = 0; c < 1030; c++) begin
            #3;
            if (c == 1024) begin
                checks++;
                if (to_a !== 1'b0 || to_b !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_early to=%b%b want 00", to_a, to_b);
                end
            end
            if (c == 1025) begin
                checks++;
                if (to_a !== 1'b1 || to_b !== 1'b1) begin
                    errors++;
                    $display("FAIL wd_rise to=%b%b want 11", to_a, to_b);
                end
            end
            step();
        end
        xst = 1'b0;
        step();
        step();
        #3;
        checks++;
        if (to_a !== 1'b1 || to_b !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky to=%b%b want 11", to_a, to_b);
        end
        checks++;
        if (xc_a !== (PERF ? 32'd1030 : 32'd0)) begin
            errors++;
            $display("FAIL wd_cnt got %0d want %0d", xc_a, PERF ? 1030 : 0);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ld(5'd7);
        step();
        rdr(5'd7, 1'b1, 5'd0, 1'b0);
        step();
        rst_n = 1'b0;
        #3;
        checks++;
        if (bun_b !== 10'b1111_1111_0_0) begin
            errors++;
            $display("FAIL mid_forced b=%b want 1111111100", bun_b);
        end
        step();
        rst_n = 1'b1;
        #3;
        checks++;
        if (bun_b !== 10'b1111_0000_1_0 || lc_b !== 32'd0 || to_b !== 1'b0) begin
            errors++;
            $display("FAIL mid_after b=%b lc=%0d want 1111000010 0",
                     bun_b, lc_b);
        end
        step();
    endtask

    // Reference: each pending load carries its age in un-held cycles and
    // stays visible until that age reaches the configured latency.
    int  m_age [2][4];
    int  m_rd  [2][4];
    bit  m_v   [2][4];
    bit  m_pxs [2];
    int  m_wd  [2];
    bit  m_to  [2];
    int  m_lc  [2];
    int  m_xc  [2];
    int  m_fc  [2];
    int  m_lat [2] = '{1, 3};
    int  m_fd  [2] = '{3, 2};

    task automatic test_random();
        bit         hz, xsc, done;
        logic [9:0] eb, gb;
        logic       gto;
        logic [95:0] gc, ec;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 4; k++) m_v[m][k] = 1'b0;
            m_pxs[m] = 1'b0; m_wd[m] = 0; m_to[m] = 1'b0;
            m_lc[m] = 0; m_xc[m] = 0; m_fc[m] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_load  = ($urandom_range(0, 4) < 2);
            rs1      = 5'(pool[$urandom_range(0, 4)]);
            rs2      = 5'(pool[$urandom_range(0, 4)]);
            rd       = 5'(pool[$urandom_range(0, 4)]);
            rs1_used = $urandom_range(0, 1) != 0;
            rs2_used = $urandom_range(0, 1) != 0;
            jbt      = ($urandom_range(0, 9) == 0);
            inv      = ($urandom_range(0, 9) == 0);
            xst      = xst ? ($urandom_range(0, 2) != 0)
                           : ($urandom_range(0, 7) == 0);
            #3;
            for (int m = 0; m < 2; m++) begin
                hz = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (m_v[m][k] &&
                        ((rs1_used && m_rd[m][k] == int'(rs1)) ||
                         (rs2_used && m_rd[m][k] == int'(rs2))))
                        hz = 1'b1;
                end
                hz = hz && id_valid;
                if (!rst_n)     eb = 10'b1111_1111_0_0;
                else if (jbt)   eb = {4'b1111, 4'((1 << m_fd[m]) - 1), 2'b10};
                else if (hz)    eb = 10'b1110_0010_0_1;
                else if (xst)   eb = 10'b1100_0000_0_0;
                else if (inv)   eb = 10'b1111_0010_1_0;
                else            eb = 10'b1111_0000_1_0;
                gb  = (m == 0) ? bun_a : bun_b;
                gto = (m == 0) ? to_a : to_b;
                gc  = (m == 0) ? {lc_a, xc_a, fc_a} : {lc_b, xc_b, fc_b};
                ec  = PERF ? {32'(m_lc[m]), 32'(m_xc[m]), 32'(m_fc[m])}
                           : 96'd0;
                checks++;
                if (gb !== eb || gto !== m_to[m] || gc !== ec) begin
                    errors++;
                    $display("FAIL rand c%0d m%0d out=%b to=%b cnt=%h want %b %b %h",
                             c, m, gb, gto, gc, eb, m_to[m], ec);
                end
                if (!rst_n) begin
                    for (int k = 0; k < 4; k++) m_v[m][k] = 1'b0;
                    m_pxs[m] = 1'b0; m_wd[m] = 0; m_to[m] = 1'b0;
                    m_lc[m] = 0; m_xc[m] = 0; m_fc[m] = 0;
                end else begin
                    xsc = !jbt && !hz && xst;
                    if (!xsc) begin
                        for (int k = 0; k < 4; k++) begin
                            if (m_v[m][k]) begin
                                m_age[m][k]++;
                                if (m_age[m][k] >= m_lat[m]) m_v[m][k] = 1'b0;
                            end
                        end
                    end
                    if (!jbt && !hz && !xst && id_valid && id_load && rd != 0) begin
                        done = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            if (!done && !m_v[m][k]) begin
                                m_v[m][k] = 1'b1; m_age[m][k] = 0;
                                m_rd[m][k] = int'(rd); done = 1'b1;
                            end
                        end
                    end
                    if (m_pxs[m] && xst)
                        m_wd[m] = (m_wd[m] < 65535) ? m_wd[m] + 1 : m_wd[m];
                    else
                        m_wd[m] = 0;
                    if (m_wd[m] >= 1024) m_to[m] = 1'b1;
                    m_pxs[m] = xsc;
                    if (jbt)      m_fc[m]++;
                    else if (hz)  m_lc[m]++;
                    else if (xsc) m_xc[m]++;
                end
            end
            step();
        end
        rst_n = 1'b1;
        clr();
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        test_reset();
        test_load_use();
        test_lat3();
        test_x0_unused();
        test_redirect();
        test_priority();
        test_hold();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter LOAD_LAT, default 1, legal 1..3: cycles after a load leaves ID before its result is forwardable.
REQ-002 Parameter FLUSH_DEPTH, default 3, legal 1..3: pipeline registers flushed on redirect, counted from IF/ID upward.
REQ-003 Parameter STALL_TIMEOUT, default 1024: ext_stall watchdog limit, in cycles.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Ports id_valid / id_load, input, 1 each: ID holds a valid instruction / that instruction is a load.
REQ-007 Ports id_rs1, id_rs2, id_rd, input, 5 each: ID source and destination register indices.
REQ-008 Ports id_rs1_used / id_rs2_used, input, 1 each: the ID instruction reads rs1 / rs2.
REQ-009 Ports jump_branch_taken / invalid_inst / ext_stall, input, 1 each: redirect from EX / illegal instruction in ID / multi-cycle unit busy.
REQ-010 Ports stage_en and stage_flush, output, 4 each: bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-011 Ports pc_en / load_stall / stall_timeout, output, 1 each.
REQ-012 Ports load_stall_cnt / ext_stall_cnt / flush_cnt, output, 32 each: performance counters.

Function
REQ-013 Scoreboard: LOAD_LAT-entry shift register; each entry holds a valid bit and a 5-bit rd; entry0 is the youngest.
REQ-014 Entry0 loads id_valid&&id_load&&(id_rd!=0) only when ID advances (no redirect, no load hazard, no ext_stall); otherwise it loads invalid. Entries i>0 take entry i-1.
REQ-015 The scoreboard holds all entries when ext_stall is the active cause; under a load stall it shifts with a bubble into entry0.
REQ-016 A redirect leaves entries >0 intact; entry0 loads invalid.
REQ-017 load_hazard = id_valid AND some valid entry has rd equal to id_rs1 with id_rs1_used, or equal to id_rs2 with id_rs2_used; combinational.
REQ-018 Default outputs: stage_en=4'b1111, stage_flush=0, pc_en=1, load_stall=0.
REQ-019 Priority, highest first: jump_branch_taken, load_hazard, ext_stall, invalid_inst.
REQ-020 Redirect: stage_flush[FLUSH_DEPTH-1:0]=1.
REQ-021 Load hazard: stage_en[0]=0, pc_en=0, stage_flush[1]=1, load_stall=1.
REQ-022 ext_stall: stage_en[1:0]=0, pc_en=0.
REQ-023 invalid_inst: stage_flush[1]=1.
REQ-024 FSM states RUN, LSTALL, XSTALL; the registered next state equals the cause chosen this cycle (load hazard→LSTALL, ext_stall→XSTALL, else RUN).
REQ-025 A redirect forces RUN.
REQ-026 Watchdog: 16-bit counter increments each cycle in XSTALL with ext_stall high; any other cycle clears it.
REQ-027 When the watchdog reaches STALL_TIMEOUT, stall_timeout sets; it is sticky until reset.
REQ-028 With LOAD_LAT=1, the outputs are cycle-identical to the previous single-cycle hazard unit.

Reset
REQ-029 When rst_n is sampled low, all scoreboard entries become invalid, the FSM goes to RUN, the watchdog clears, stall_timeout clears and all counters clear.
REQ-030 While rst_n is low, outputs are forced combinationally: stage_flush=4'b1111, stage_en=4'b1111, pc_en=0, load_stall=0.

Configuration
REQ-031 With macro HAZARD_PERF_CNT_EN defined: load_stall_cnt, ext_stall_cnt and flush_cnt each increment by 1 per cycle of their cause, saturating at 32'hFFFFFFFF.
REQ-032 flush_cnt counts redirect cycles only.
REQ-033 Without HAZARD_PERF_CNT_EN: the counter ports remain, are tied to 0, and no counter flops exist.

Verification
REQ-034 LOAD_LAT=1: load x5 enters EX, then ID add x6,x5,x1 → one cycle of load_stall=1, stage_en=4'b1110, stage_flush=4'b0010; the add issues next cycle.
REQ-035 LOAD_LAT=3: load x7, then dependent reader in ID → 3 consecutive stall cycles; a reader of x8 instead → no stall.
REQ-036 Load to x0 followed by reader of x0 → no stall; reader with rs2=x5 and id_rs2_used=0 after load x5 → no stall.
REQ-037 jump_branch_taken and load_hazard in the same cycle with FLUSH_DEPTH=2 → stage_flush=4'b0011, load_stall=0, pc_en=1, FSM goes to RUN.
REQ-038 ext_stall held 1030 cycles with STALL_TIMEOUT=1024 → stall_timeout rises after the 1024th XSTALL cycle and stays 1 after ext_stall drops; ext_stall_cnt=1030 when HAZARD_PERF_CNT_EN is defined.
REQ-039 rst_n driven low mid-LSTALL → next cycle: entries invalid, state RUN, load_stall=0, counters=0.
